// File: rtl/encoder_4to2.sv
// Registered MSB-priority encoder, one-cycle latency, enable-gated.
// Optional ENCODER_ONEHOT_CHECK_EN adds a registered multi-hot err flag.
module encoder_4to2 #(
  parameter  int IN_W  = 4,
  localparam int OUT_W = $clog2(IN_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [IN_W-1:0]  in,
`ifdef ENCODER_ONEHOT_CHECK_EN
  output logic             err,
`endif
  output logic [OUT_W-1:0] out,
  output logic             valid
);

  logic [OUT_W-1:0] idx;
  logic             hit;
  logic [OUT_W-1:0] out_d, out_q;
  logic             valid_d, valid_q;

  // Ascending scan so the highest set bit is the last one written.
  always_comb begin
    idx = '0;
    for (int i = 0; i < IN_W; i++) begin
      if (in[i]) idx = i[OUT_W-1:0];
    end
  end

  assign hit     = en && (|in);
  assign out_d   = hit ? idx : '0;
  assign valid_d = hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      out_q   <= out_d;
      valid_q <= valid_d;
    end
  end

  assign out   = out_q;
  assign valid = valid_q;

`ifdef ENCODER_ONEHOT_CHECK_EN
  logic err_d, err_q;

  // Clearing the lowest set bit leaves a residue only when multi-hot.
  assign err_d = en && (|(in & (in - IN_W'(1))));

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign err = err_q;
`endif

endmodule

// File: tb/tb_encoder_4to2.sv
// Self-checking bench for encoder_4to2: directed plan plus random stimulus
// against a log2/popcount reference model.
module tb_encoder_4to2;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [3:0] req;
  logic [1:0] out;
  logic       valid;
`ifdef ENCODER_ONEHOT_CHECK_EN
  logic       err;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  encoder_4to2 dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .in   (req),
`ifdef ENCODER_ONEHOT_CHECK_EN
    .err  (err),
`endif
    .out  (out),
    .valid(valid)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Apply inputs, clock once, then compare against the model.
  task automatic step(input string tag, input logic r,
                      input logic e, input logic [3:0] v);
    int exp_out;
    int exp_val;
    int exp_err;
    rst = r;
    en  = e;
    req = v;
    @(posedge clk);
    #1;
    exp_out = 0;
    exp_val = 0;
    exp_err = 0;
    if (!r && e && v != 0) begin
      exp_out = $clog2(int'(v) + 1) - 1;
      exp_val = 1;
    end
    if (!r && e && $countones(v) > 1) exp_err = 1;
    check({tag, ".out"}, 32'(out), 32'(exp_out));
    check({tag, ".valid"}, 32'(valid), 32'(exp_val));
`ifdef ENCODER_ONEHOT_CHECK_EN
    check({tag, ".err"}, 32'(err), 32'(exp_err));
`else
    if (exp_err > 1) $display("unreachable");
`endif
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b1;
    req = 4'b1000;
    #1;
    step("rst0", 1, 1, 4'b1000);
    step("rst1", 1, 1, 4'b1000);
    step("rel", 0, 1, 4'b1000);

    step("oh0", 0, 1, 4'b0001);
    step("oh1", 0, 1, 4'b0010);
    step("oh2", 0, 1, 4'b0100);
    step("oh3", 0, 1, 4'b1000);

    step("dis0", 0, 0, 4'b0001);
    step("dis1", 0, 0, 4'b0010);
    step("dis2", 0, 0, 4'b0100);
    step("dis3", 0, 0, 4'b1000);

    step("zero", 0, 1, 4'b0000);
    step("togA", 0, 1, 4'b0100);
    step("togB", 0, 0, 4'b0100);

    step("mh0110", 0, 1, 4'b0110);
    step("mh1011", 0, 1, 4'b1011);
    step("mh0011", 0, 1, 4'b0011);
    step("mh0100", 0, 1, 4'b0100);

    step("midA", 0, 1, 4'b0010);
    step("midR", 1, 1, 4'b0010);
    step("midB", 0, 1, 4'b0010);

    for (int i = 0; i < 300; i++) begin
      step("rnd", ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 3) != 0),
           4'($urandom_range(0, 15)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/encoder_4to2.md
Name: encoder_4to2

Overview:
- Registered priority encoder that converts a one-hot request vector into its binary index.
- Default configuration is 4-to-2, with an enable input gating the conversion.
- Sits between request/select logic and downstream index-consuming logic.
- Output is registered: one cycle of latency, glitch-free index and valid.

Parameters:
- IN_W, 4, width of the input request vector; must be ≥2 and a power of two.
- OUT_W, $clog2(IN_W) (2 at default), width of the encoded index output; derived, not to be overridden.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- en  input  1  encode enable; when low, outputs are forced to zero on the next edge.
- in  input  IN_W  request vector, nominally one-hot.
- out  output  OUT_W  registered binary index of the highest set bit of in.
- valid  output  1  registered; high when out reflects a non-zero input captured while en=1.

Behaviour:
- Reset: on a clk edge with rst=1, out=0 and valid=0; rst has priority over en and in.
- Latency: exactly 1 cycle. Inputs sampled at edge N appear on out/valid after edge N.
- en=1, in≠0:
  - out <= index of the most significant set bit (priority encoding; MSB wins).
  - valid <= 1.
- en=1, in=0: out <= 0, valid <= 0.
- en=0: out <= 0, valid <= 0, regardless of in.
- One-hot mapping at default width:
  - 0001 -> 00
  - 0010 -> 01
  - 0100 -> 10
  - 1000 -> 11
- Multi-hot input (e.g. 0110) is legal; it is resolved by priority (0110 -> 10).
- The encoder is purely combinational from in to the register D input; no internal state beyond the output registers (and the optional error register).
- Reset asserted mid-stream clears outputs on that edge; the first valid result after reset deassertion appears one cycle after the first sampled enabled non-zero input.
- No X propagation: outputs are always driven from registers.

Optional Feature:
- Macro: ENCODER_ONEHOT_CHECK_EN
- Defined:
  - Adds output port err (1 bit, registered, reset 0).
  - err <= 1 when en=1 and in has more than one bit set; otherwise err <= 0.
  - Same 1-cycle latency as out; out/valid behaviour is unchanged (priority still applies).
- Undefined:
  - Port err and its logic are absent.
  - Multi-hot inputs are silently priority-resolved.

Test Plan:
- Reset: rst=1 for 2 cycles with en=1, in=1000 -> out=00, valid=0 throughout; rst=0 -> next cycle out=11, valid=1.
- Enabled one-hot sweep: en=1; in=0001, 0010, 0100, 1000 on consecutive cycles -> out=00, 01, 10, 11 one cycle later each, valid=1.
- Disabled sweep: en=0; same in sequence -> out=00, valid=0 on every cycle.
- Zero input: en=1, in=0000 -> out=00, valid=0; toggle en 1->0 mid-sequence with in=0100 -> out goes 10 then 00 on the following edge.
- Multi-hot priority: en=1; in=0110 -> out=10; in=1011 -> out=11; in=0011 -> out=01; valid=1. With ENCODER_ONEHOT_CHECK_EN: err=1 for each of these and err=0 for in=0100.
- Sync reset mid-operation: en=1, in=0010 steady; assert rst for one cycle -> out=00, valid=0 on that edge only; recovers to out=01, valid=1 on the next edge.
